// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame link: state encoding and the default
// frame geometry. The receive-side run-of-ones detector imports the same
// defaults, so both ends agree on the preamble length.
package serial_frame_tx_pkg;

  // Default payload width in bits.
  localparam int DEF_DATA_W  = 8;
  // Default preamble length in ones. A payload run of DEF_PRE_LEN-1 ones is
  // followed by a stuffed zero.
  localparam int DEF_PRE_LEN = 3;

  // Transmit FSM states. Encodings 5..7 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

endpackage

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter. It takes one parallel word and sends one frame on a
// 1-bit line:
//   PRE_LEN ones | DATA_W payload bits, MSB first, zero-stuffed | one guard zero
// A zero is stuffed after every PRE_LEN-1 consecutive payload ones, except after
// the last payload bit, where the guard zero does the same job. Payload runs of
// ones therefore stay shorter than PRE_LEN, and only a preamble can produce a
// run of PRE_LEN ones on the line.
//
// Handshake: ready is high only in IDLE. A word is accepted on a rising CLK
// edge where load && ready, and data_in is captured on that edge. If load is
// asserted while ready is low, it is ignored and nothing is queued. data_in has
// no effect after capture. If load is held high, the next word is accepted on
// the edge after GUARD, which leaves exactly one idle zero cycle between frames.
//
// out, done and ready are flops loaded from the next-state decode. The line is
// therefore glitch-free and follows the state one-for-one: the first preamble
// one appears in the cycle after the accepting edge. fsm_state exposes the
// current state for observation.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PRE_LEN = DEF_PRE_LEN
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              out,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int RW = $clog2(PRE_LEN + 1);

  // Value of bit_cnt while the last payload bit is on the line.
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  // Value of pre_cnt during the final preamble cycle.
  localparam logic [RW-1:0] PRE_LAST = RW'(PRE_LEN - 1);
  // Run length of payload ones that forces a stuffed zero.
  localparam logic [RW-1:0] STUFF_AT = RW'(PRE_LEN - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift_reg, shift_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [RW-1:0]     pre_cnt, pre_cnt_n;
  logic [RW-1:0]     run, run_n;
  logic              out_n, done_n, ready_n;
  logic              cur_bit;
  logic [RW-1:0]     run_inc;

  // State, counters, shift register and registered outputs.
  // The asynchronous reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
      run       <= '0;
      out       <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_cnt_n;
      pre_cnt   <= pre_cnt_n;
      run       <= run_n;
      out       <= out_n;
      done      <= done_n;
      ready     <= ready_n;
    end
  end

  // Next-state logic and counter updates. The outputs are then decoded from
  // the next state, so each flop holds the value for the cycle it starts.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_cnt_n = bit_cnt;
    pre_cnt_n = pre_cnt;
    run_n     = run;
    cur_bit   = shift_reg[DATA_W-1];
    run_inc   = run + RW'(1);

    case (state)
      ST_IDLE: begin
        if (load && ready) begin
          shift_n   = data_in;
          bit_cnt_n = '0;
          pre_cnt_n = '0;
          run_n     = '0;
          state_n   = ST_PRE;
        end
      end
      ST_PRE: begin
        // Preamble ones are kept out of the run counter.
        if (pre_cnt == PRE_LAST) begin
          pre_cnt_n = '0;
          state_n   = ST_DATA;
        end else begin
          pre_cnt_n = pre_cnt + RW'(1);
        end
      end
      ST_DATA: begin
        shift_n   = shift_reg << 1;
        bit_cnt_n = bit_cnt + CW'(1);
        run_n     = cur_bit ? run_inc : '0;
        if (bit_cnt == LAST_BIT) begin
          state_n = ST_GUARD;
        end else if (cur_bit && (run_inc == STUFF_AT)) begin
          state_n = ST_STUFF;
        end
      end
      ST_STUFF: begin
        run_n   = '0;
        state_n = ST_DATA;
      end
      ST_GUARD: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    out_n   = (state_n == ST_PRE) || ((state_n == ST_DATA) && shift_n[DATA_W-1]);
    done_n  = (state_n == ST_GUARD);
    ready_n = (state_n == ST_IDLE);
  end

  assign busy      = ~ready;
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx. A reference model builds each
// expected frame from the framing rules: preamble ones, payload bits MSB first
// with a zero after every PRE_LEN-1 payload ones except after the last bit,
// then a guard zero. The bench compares the line with that frame cycle by
// cycle. It also counts how many times the line reaches a run of PRE_LEN ones,
// as the receive-side detector would see it.
module tb_serial_frame_tx;
  import serial_frame_tx_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int PL = DEF_PRE_LEN;

  // Clock and reset.
  logic          CLK = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic          load;
  logic          ready, busy, out, done;
  logic [2:0]    fsm_state;

  always #5 CLK = ~CLK;

  serial_frame_tx #(.DATA_W(DW), .PRE_LEN(PL)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .busy      (busy),
    .out       (out),
    .done      (done),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected line bits for the current frame.
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected line sequence for one payload word.
  task automatic build_expected(input logic [DW-1:0] d);
    int ones;
    exp_q.delete();
    for (int k = 0; k < PL; k++) exp_q.push_back(1'b1);
    ones = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      ones = d[i] ? ones + 1 : 0;
      if (i != 0 && ones == PL - 1) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    exp_q.push_back(1'b0);
  endtask

  // Driver: send one word and check every line cycle against the model.
  // inject_at >= 0 pulses load with 8'h3C during that frame cycle.
  // hold keeps load high through the frame.
  // expect_now requires acceptance without waiting.
  task automatic run_frame(input logic [DW-1:0] d, input int inject_at,
                           input bit hold, input bit expect_now);
    int waited, n, line_run, dets;
    build_expected(d);
    n = exp_q.size();
    data_in = d;
    load    = 1'b1;
    waited  = 0;
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("ready_before_load", ready, 1);
    if (expect_now) check("b2b_wait_cycles", waited, 0);
    @(posedge CLK);
    @(negedge CLK);
    load     = hold;
    line_run = 0;
    dets     = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      check($sformatf("out_d%02h_c%0d", d, i), out, exp_q[i]);
      check($sformatf("done_d%02h_c%0d", d, i), done, (i == n - 1));
      check($sformatf("ready_d%02h_c%0d", d, i), ready, 0);
      check($sformatf("busy_d%02h_c%0d", d, i), busy, 1);
      line_run = out ? line_run + 1 : 0;
      if (line_run == PL) dets++;
      if (i == inject_at) begin
        load    = 1'b1;
        data_in = 8'h3C;
      end else begin
        if (inject_at >= 0 && i == inject_at + 1) load = hold;
        data_in = DW'($urandom);
      end
    end
    @(negedge CLK);
    check($sformatf("ready_after_d%02h", d), ready, 1);
    check($sformatf("busy_after_d%02h", d), busy, 0);
    check($sformatf("out_after_d%02h", d), out, 0);
    check($sformatf("done_after_d%02h", d), done, 0);
    check($sformatf("detections_d%02h", d), dets, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    data_in = '0;

    // Reset state.
    @(negedge CLK);
    check("rst_out", out, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_out", out, 0);
    check("post_rst_ready", ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    // Directed frames: no stuffing, maximum stuffing, all zeros.
    run_frame(8'hA5, -1, 1'b0, 1'b0);
    run_frame(8'hFF, -1, 1'b0, 1'b0);
    run_frame(8'h00, -1, 1'b0, 1'b0);

    // A load pulse during DATA is ignored.
    run_frame(8'hA5, 6, 1'b0, 1'b0);

    // Reset in the middle of DATA drops the line at once.
    data_in = 8'hA5;
    load    = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    load = 1'b0;
    repeat (5) @(negedge CLK);
    reset_n = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    check("midrst_rel_ready", ready, 1);
    check("midrst_rel_out", out, 0);
    run_frame(8'h81, -1, 1'b0, 1'b0);

    // Back-to-back frames with load held high.
    run_frame(DW'($urandom), -1, 1'b1, 1'b0);
    run_frame(DW'($urandom), -1, 1'b0, 1'b1);

    // Random payloads.
    for (int r = 0; r < 12; r++) begin
      run_frame(DW'($urandom), -1, 1'($urandom_range(0, 1)), 1'b0);
    end
    load = 1'b0;
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
